// File: rtl/cuckoo_timekeeper_if.sv
// Signal bundle between the timekeeper and its controller: time set/readout,
// the one-second strobe input and the cuckoo actuator outputs.
`timescale 1ns/1ps
interface cuckoo_timekeeper_if;
  logic       sigClk;
  logic       set_en;
  logic [4:0] set_hour;
  logic [5:0] set_min;
  logic [5:0] set_sec;
  logic       chime_en;
  logic [4:0] hour;
  logic [5:0] min;
  logic [5:0] sec;
  logic       set_err;
  logic       cuckoo;
  logic       busy;
  logic [3:0] strikes_left;

  modport master (
    output sigClk, set_en, set_hour, set_min, set_sec, chime_en,
    input  hour, min, sec, set_err, cuckoo, busy, strikes_left
  );

  modport slave (
    input  sigClk, set_en, set_hour, set_min, set_sec, chime_en,
    output hour, min, sec, set_err, cuckoo, busy, strikes_left
  );
endinterface

// File: rtl/cuckoo_timekeeper.sv
// 24-hour time-of-day counter advanced by sigClk rising edges, with an hourly
// cuckoo strike sequencer (1..12 calls separated by gaps).
`timescale 1ns/1ps
module cuckoo_timekeeper #(
  parameter int CALL_CYC = 1250000,
  parameter int GAP_CYC  = 1250000
) (
  input  logic               sysclk,
  input  logic               rst_n,
  cuckoo_timekeeper_if.slave bus
);

  localparam int MAX_CYC = (CALL_CYC > GAP_CYC) ? CALL_CYC : GAP_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam int TW      = (CW > 21) ? CW : 21;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALL = 2'd1,
    GAP  = 2'd2
  } state_t;

  logic          sig_q;
  logic [4:0]    hour_q, hour_d;
  logic [5:0]    min_q, min_d;
  logic [5:0]    sec_q, sec_d;
  logic          set_err_q;
  state_t        state_q;
  logic [TW-1:0] timer_q;
  logic [3:0]    strikes_q;
  logic          cuckoo_q;
  logic          busy_q;

  logic          tick;
  logic          set_ok;
  logic          trigger;
  logic [4:0]    next_hour;
  logic [4:0]    hour_mod;
  logic [3:0]    strike_cnt;

  assign tick   = bus.sigClk && !sig_q;
  assign set_ok = bus.set_en && (bus.set_hour <= 5'd23) &&
                  (bus.set_min <= 6'd59) && (bus.set_sec <= 6'd59);

  // A valid load wins over a coincident tick, so it can never cause a strike.
  assign trigger   = tick && !set_ok && (sec_q == 6'd59) && (min_q == 6'd59);
  assign next_hour = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
  assign hour_mod  = (next_hour >= 5'd12) ? next_hour - 5'd12 : next_hour;
  assign strike_cnt = (hour_mod == 5'd0) ? 4'd12 : hour_mod[3:0];

  always_comb begin
    hour_d = hour_q;
    min_d  = min_q;
    sec_d  = sec_q;
    if (set_ok) begin
      hour_d = bus.set_hour;
      min_d  = bus.set_min;
      sec_d  = bus.set_sec;
    end else if (tick) begin
      if (sec_q == 6'd59) begin
        sec_d = 6'd0;
        if (min_q == 6'd59) begin
          min_d  = 6'd0;
          hour_d = next_hour;
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end
  end

  // sig_q follows sigClk even in reset so a high level at release is not a tick.
  always_ff @(posedge sysclk) begin
    sig_q <= bus.sigClk;
    if (!rst_n) begin
      hour_q    <= 5'd0;
      min_q     <= 6'd0;
      sec_q     <= 6'd0;
      set_err_q <= 1'b0;
    end else begin
      hour_q    <= hour_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      set_err_q <= bus.set_en && !set_ok;
    end
  end

  always_ff @(posedge sysclk) begin
    if (!rst_n || !bus.chime_en) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      strikes_q <= 4'd0;
      cuckoo_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (trigger) begin
            state_q   <= CALL;
            timer_q   <= TW'(CALL_CYC);
            strikes_q <= strike_cnt;
            cuckoo_q  <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        CALL: begin
          if (timer_q <= TW'(1)) begin
            cuckoo_q <= 1'b0;
            if (strikes_q > 4'd1) begin
              state_q   <= GAP;
              timer_q   <= TW'(GAP_CYC);
              strikes_q <= strikes_q - 4'd1;
            end else begin
              state_q   <= IDLE;
              timer_q   <= '0;
              strikes_q <= 4'd0;
              busy_q    <= 1'b0;
            end
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        GAP: begin
          if (timer_q <= TW'(1)) begin
            state_q  <= CALL;
            timer_q  <= TW'(CALL_CYC);
            cuckoo_q <= 1'b1;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        default: begin
          state_q   <= IDLE;
          timer_q   <= '0;
          strikes_q <= 4'd0;
          cuckoo_q  <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.hour         = hour_q;
  assign bus.min          = min_q;
  assign bus.sec          = sec_q;
  assign bus.set_err      = set_err_q;
  assign bus.cuckoo       = cuckoo_q;
  assign bus.busy         = busy_q;
  assign bus.strikes_left = strikes_q;

endmodule

// File: tb/tb_cuckoo_timekeeper.sv
// Directed bench for cuckoo_timekeeper with CALL_CYC=4, GAP_CYC=3.
`timescale 1ns/1ps
module tb_cuckoo_timekeeper;

  logic sysclk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  int   mon_calls;
  logic mon_prev;

  cuckoo_timekeeper_if bus();

  cuckoo_timekeeper #(.CALL_CYC(4), .GAP_CYC(3)) dut (
    .sysclk (sysclk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  initial begin
    mon_calls = 0;
    mon_prev  = 1'b0;
  end

  always @(negedge sysclk) begin
    if (bus.cuckoo === 1'b1 && mon_prev !== 1'b1) mon_calls++;
    mon_prev = bus.cuckoo;
  end

  initial begin
    #900000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load(input int h, input int m, input int s);
    bus.set_en   = 1'b1;
    bus.set_hour = 5'(h);
    bus.set_min  = 6'(m);
    bus.set_sec  = 6'(s);
    step();
    bus.set_en   = 1'b0;
  endtask

  // Returns right after the tick edge, with sigClk already lowered again.
  task automatic tick_edge();
    bus.sigClk = 1'b0;
    step();
    bus.sigClk = 1'b1;
    step();
    bus.sigClk = 1'b0;
  endtask

  task automatic chk_time(input string tag, input int h, input int m, input int s);
    chk({tag, "_hour"}, 32'(bus.hour), 32'(h));
    chk({tag, "_min"},  32'(bus.min),  32'(m));
    chk({tag, "_sec"},  32'(bus.sec),  32'(s));
  endtask

  task automatic run_strike(output int calls, output int busy_cyc, output int high_cyc);
    logic prev;
    calls = 0; busy_cyc = 0; high_cyc = 0; prev = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (bus.busy !== 1'b1) break;
      busy_cyc++;
      if (bus.cuckoo === 1'b1) begin
        high_cyc++;
        if (!prev) calls++;
      end
      prev = bus.cuckoo;
      step();
    end
    chk("strike_end_idle", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int calls, busy_cyc, high_cyc, total_calls, seqs, c0;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.sigClk = 1'b0; bus.set_en = 1'b0; bus.chime_en = 1'b1;
    bus.set_hour = '0; bus.set_min = '0; bus.set_sec = '0;
    repeat (3) step();
    chk_time("reset", 0, 0, 0);
    chk("reset_busy",    32'(bus.busy), 32'd0);
    chk("reset_cuckoo",  32'(bus.cuckoo), 32'd0);
    chk("reset_strikes", 32'(bus.strikes_left), 32'd0);
    chk("reset_set_err", 32'(bus.set_err), 32'd0);
    rst_n = 1'b1;
    step();

    // 13:00 strike: single call, no gap
    load(12, 59, 58);
    chk_time("load_125958", 12, 59, 58);
    tick_edge();
    chk_time("t_125959", 12, 59, 59);
    chk("t_125959_busy", 32'(bus.busy), 32'd0);
    tick_edge();
    chk_time("t_130000", 13, 0, 0);
    chk("h13_busy",    32'(bus.busy), 32'd1);
    chk("h13_strikes", 32'(bus.strikes_left), 32'd1);
    chk("h13_cuckoo",  32'(bus.cuckoo), 32'd1);
    run_strike(calls, busy_cyc, high_cyc);
    chk("h13_calls", 32'(calls), 32'd1);
    chk("h13_busy_cyc", 32'(busy_cyc), 32'd4);
    chk("h13_strikes_end", 32'(bus.strikes_left), 32'd0);

    // midnight: 12 calls
    load(23, 59, 59);
    tick_edge();
    chk_time("t_000000", 0, 0, 0);
    chk("h0_strikes", 32'(bus.strikes_left), 32'd12);
    run_strike(calls, busy_cyc, high_cyc);
    chk("h0_calls", 32'(calls), 32'd12);
    chk("h0_busy_cyc", 32'(busy_cyc), 32'd81);
    chk("h0_high_cyc", 32'(high_cyc), 32'd48);

    // invalid load with coincident tick, then valid load with coincident tick
    load(5, 10, 20);
    bus.sigClk = 1'b1;
    bus.set_en = 1'b1; bus.set_hour = 5'd5; bus.set_min = 6'd60; bus.set_sec = 6'd0;
    step();
    bus.sigClk = 1'b0; bus.set_en = 1'b0;
    chk_time("bad_set_tick", 5, 10, 21);
    chk("bad_set_err", 32'(bus.set_err), 32'd1);
    step();
    chk("bad_set_err_clr", 32'(bus.set_err), 32'd0);
    bus.sigClk = 1'b1;
    bus.set_en = 1'b1; bus.set_hour = 5'd7; bus.set_min = 6'd0; bus.set_sec = 6'd0;
    step();
    bus.sigClk = 1'b0; bus.set_en = 1'b0;
    chk_time("good_set_tick", 7, 0, 0);
    chk("good_set_busy", 32'(bus.busy), 32'd0);
    chk("good_set_err", 32'(bus.set_err), 32'd0);
    step();
    chk("good_set_busy2", 32'(bus.busy), 32'd0);

    // 3 o'clock: drop chime_en during the second gap
    load(2, 59, 59);
    tick_edge();
    chk("h3_strikes", 32'(bus.strikes_left), 32'd3);
    repeat (11) step();
    chk("h3_gap2_cuckoo",  32'(bus.cuckoo), 32'd0);
    chk("h3_gap2_strikes", 32'(bus.strikes_left), 32'd1);
    chk("h3_gap2_busy",    32'(bus.busy), 32'd1);
    bus.chime_en = 1'b0;
    step();
    chk("abort_busy",    32'(bus.busy), 32'd0);
    chk("abort_cuckoo",  32'(bus.cuckoo), 32'd0);
    chk("abort_strikes", 32'(bus.strikes_left), 32'd0);
    bus.chime_en = 1'b1;
    repeat (10) step();
    chk("abort_no_resume", 32'(bus.busy), 32'd0);
    load(3, 59, 59);
    tick_edge();
    chk("h4_strikes", 32'(bus.strikes_left), 32'd4);
    run_strike(calls, busy_cyc, high_cyc);
    chk("h4_calls", 32'(calls), 32'd4);
    chk("h4_busy_cyc", 32'(busy_cyc), 32'd25);

    // trigger and load during an active sequence are ignored
    load(0, 59, 59);
    tick_edge();
    chk("h1_strikes", 32'(bus.strikes_left), 32'd1);
    load(1, 59, 59);
    chk("h1_load_strikes", 32'(bus.strikes_left), 32'd1);
    chk("h1_load_busy",    32'(bus.busy), 32'd1);
    tick_edge();
    chk_time("t_020000", 2, 0, 0);
    chk("h2_ignored_strikes", 32'(bus.strikes_left), 32'd1);
    step();
    chk("h2_ignored_busy", 32'(bus.busy), 32'd0);

    // sigClk held high across reset release
    rst_n = 1'b0;
    bus.sigClk = 1'b1;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (2) step();
    chk("rst_high_no_tick", 32'(bus.sec), 32'd0);
    bus.sigClk = 1'b0;
    step();
    bus.sigClk = 1'b1;
    step();
    bus.sigClk = 1'b0;
    chk("rst_first_tick", 32'(bus.sec), 32'd1);

    // reset during CALL
    load(5, 59, 59);
    tick_edge();
    chk("h6_busy",    32'(bus.busy), 32'd1);
    chk("h6_strikes", 32'(bus.strikes_left), 32'd6);
    step();
    rst_n = 1'b0;
    step();
    chk_time("mid_rst", 0, 0, 0);
    chk("mid_rst_cuckoo",  32'(bus.cuckoo), 32'd0);
    chk("mid_rst_busy",    32'(bus.busy), 32'd0);
    chk("mid_rst_strikes", 32'(bus.strikes_left), 32'd0);
    chk("mid_rst_set_err", 32'(bus.set_err), 32'd0);
    rst_n = 1'b1;
    step();

    // out-of-range hour only
    load(24, 0, 0);
    chk_time("bad_hour", 0, 0, 0);
    chk("bad_hour_err", 32'(bus.set_err), 32'd1);

    // every hour rollover of a day: 24 sequences, 156 calls
    total_calls = 0;
    seqs = 0;
    for (int h = 0; h < 24; h++) begin
      load(h, 59, 59);
      tick_edge();
      chk("sweep_hour", 32'(bus.hour), 32'((h + 1) % 24));
      run_strike(calls, busy_cyc, high_cyc);
      total_calls += calls;
      if (calls > 0) seqs++;
    end
    chk("day_sequences", 32'(seqs), 32'd24);
    chk("day_calls", 32'(total_calls), 32'd156);

    // continuous ticks across an hour boundary
    load(0, 0, 0);
    c0 = mon_calls;
    repeat (3661) tick_edge();
    repeat (20) step();
    chk_time("run_3661", 1, 1, 1);
    chk("run_calls", 32'(mon_calls - c0), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cuckoo_timekeeper.md
CUCKOO_TIMEKEEPER -- requirements
Module: cuckoo_timekeeper

Interface
REQ-001 Parameter CALL_CYC, default 1250000, sysclk cycles the cuckoo output stays high per call.
REQ-002 Parameter GAP_CYC, default 1250000, sysclk cycles cuckoo stays low between calls.
REQ-003 sysclk  input  1  system clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset; one clock, reset synchronous and active-low.
REQ-005 sigClk  input  1  slow square wave from the clock divider, synchronous to sysclk; each rising edge = one second.
REQ-006 set_en  input  1  one-cycle load strobe for time-of-day.
REQ-007 set_hour / set_min / set_sec  input  5 / 6 / 6  load values.
REQ-008 chime_en  input  1  cuckoo enable level.
REQ-009 hour / min / sec  output  5 / 6 / 6  current time, 24-hour binary.
REQ-010 set_err  output  1  one-cycle pulse: load rejected.
REQ-011 cuckoo  output  1  drive to cuckoo actuator, high during a call.
REQ-012 busy  output  1  high while cuckoo FSM not IDLE.
REQ-013 strikes_left  output  4  calls remaining including the current one; 0 in IDLE.

Function
REQ-014 Tick SHALL be 1 in a cycle where sigClk=1 and registered previous sigClk (sig_q)=0; sig_q updates every cycle.
REQ-015 On tick, sec SHALL increment; 59 wraps to 0 and carries to min; min 59 wraps to 0 and carries to hour; hour 23 wraps to 0; all updates in the tick cycle (outputs change at that edge).
REQ-016 On set_en with set_hour<=23, set_min<=59, set_sec<=59, time SHALL load at that edge; a coincident tick SHALL be discarded.
REQ-017 On set_en with any field out of range, time SHALL hold, a coincident tick SHALL still apply, and set_err SHALL pulse high for exactly that next cycle.
REQ-018 Hour strike trigger SHALL fire only when a tick rolls min:sec from 59:59 to 00:00; a load to xx:00:00 SHALL NOT trigger.
REQ-019 Strike count SHALL be new hour mod 12, with 0 mapped to 12 (range 1..12).
REQ-020 FSM states IDLE, CALL, GAP; one down-counter, 21+ bits wide enough for max(CALL_CYC, GAP_CYC).
REQ-021 IDLE -> CALL on trigger with chime_en=1: strikes_left=count, timer=CALL_CYC, cuckoo=1 from next edge.
REQ-022 CALL: cuckoo=1 for exactly CALL_CYC cycles; then if strikes_left>1 -> GAP (strikes_left decrements, timer=GAP_CYC), else -> IDLE (strikes_left=0).
REQ-023 GAP: cuckoo=0 for exactly GAP_CYC cycles, then -> CALL with timer=CALL_CYC.
REQ-024 Trigger while not IDLE SHALL be ignored; current sequence continues unchanged.
REQ-025 chime_en=0 in any cycle SHALL force IDLE at the next edge: cuckoo=0, busy=0, strikes_left=0; triggers with chime_en=0 are lost, not deferred.
REQ-026 set_en SHALL NOT affect an in-progress strike sequence.

Reset
REQ-027 With rst_n=0 at an edge: hour=min=sec=0, FSM=IDLE, cuckoo=0, busy=0, strikes_left=0, set_err=0, timer=0.
REQ-028 During reset sig_q SHALL load current sigClk, so no tick is generated on the first cycle after reset if sigClk is already high.
REQ-029 Reset asserted mid-strike SHALL abort the sequence in that same edge; no tick or set_en is acted on while rst_n=0.

Verification (CALL_CYC=4, GAP_CYC=3)
REQ-030 Load 12:59:58, two sigClk rising edges -> time 13:00:00, busy=1, strikes_left=1, cuckoo high 4 cycles then IDLE, no gap.
REQ-031 Load 23:59:59, one tick -> 00:00:00, 12 calls: cuckoo pattern 4 high / 3 low x11 then 4 high, total 4*12+3*11=81 cycles busy.
REQ-032 set_en with set_min=60 coincident with tick at 05:10:20 -> time 05:10:21, set_err pulses one cycle; then valid set_en 07:00:00 with tick -> 07:00:00, no strike.
REQ-033 Strike of 3 in progress, drop chime_en in second GAP -> cuckoo=0, busy=0, strikes_left=0 next edge; next hour with chime_en=1 strikes normally.
REQ-034 Hold sigClk=1 through reset release -> no tick until sigClk falls and rises again; reset asserted during CALL -> all outputs zero at that edge.
REQ-035 Continuous ticks for 86400 s from 00:00:00 -> returns to 00:00:00, exactly 24 strike sequences with total 156 calls.
